// File: rtl/pipe_add_acc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : pipe_add_acc                                                      |
// | Brief   : Two-stage valid/ready pipelined adder / running accumulator.      |
// |           Define PIPE_ADD_ACC_SAT_EN for saturating ACC mode (else wraps).  |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module pipe_add_acc #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  generate
    if (ACC_W < WIDTH + 1) begin : g_width_check
      $error("pipe_add_acc: ACC_W must be >= WIDTH+1");
    end
  endgenerate

  localparam logic MODE_ACC = 1'b1;

  logic             en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  logic             s1_clr;
  logic [ACC_W-1:0] acc;

  logic [WIDTH:0]   add_t;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_t;
  logic [ACC_W-1:0] nxt_sum;
  logic             nxt_carry;

  // Whole pipeline advances together; in_ready depends only on output-side state.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
      s1_clr   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= mode;
        s1_clr  <= clr;
      end
    end
  end

  assign add_t    = {1'b0, s1_a} + {1'b0, s1_b};
  assign acc_base = s1_clr ? '0 : acc;
  assign acc_t    = {1'b0, acc_base} + (ACC_W + 1)'(s1_a);

  always_comb begin
    nxt_sum   = ACC_W'(add_t);
    nxt_carry = add_t[WIDTH];
    if (s1_mode == MODE_ACC) begin
`ifdef PIPE_ADD_ACC_SAT_EN
      if (acc_t[ACC_W]) begin
        nxt_sum   = {ACC_W{1'b1}};
        nxt_carry = 1'b1;
      end else begin
        nxt_sum   = acc_t[ACC_W-1:0];
        nxt_carry = 1'b0;
      end
`else
      nxt_sum   = acc_t[ACC_W-1:0];
      nxt_carry = acc_t[ACC_W];
`endif
    end
  end

  // acc commits together with the S2 result, so chained ACC ops see it next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= nxt_sum;
        carry <= nxt_carry;
        if (s1_mode == MODE_ACC) begin
          acc <= nxt_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire
